// File: rtl/mst_ch_sched.sv
// Round-robin burst scheduler for FT60x channels: IDLE -> ARB -> GRANT -> BUSY.
// Optional per-channel completed-burst counters (grt_cnt) when MST_SCHED_STAT_EN is defined.
module mst_ch_sched #(
  parameter int CNT_CHANNLS = 4,
  parameter int BURST_MAX   = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mltcn,
  input  logic [CNT_CHANNLS-1:0]         ch_nempt,
  input  logic                           txe_n,
  input  logic                           sched_req,
  input  logic                           grt_ack,
  input  logic                           word_stb,
  output logic                           grt_vld,
  output logic [$clog2(CNT_CHANNLS)-1:0] grt_chn,
  output logic [CNT_CHANNLS-1:0]         grt_oh,
  output logic                           burst_end,
  output logic [11:0]                    burst_len
`ifdef MST_SCHED_STAT_EN
  , output logic [CNT_CHANNLS*16-1:0]    grt_cnt
`endif
);

  localparam int CW = $clog2(CNT_CHANNLS);
  localparam logic [11:0] BMAX = 12'(BURST_MAX);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARB   = 2'd1;
  localparam logic [1:0] GRANT = 2'd2;
  localparam logic [1:0] BUSY  = 2'd3;

  logic [1:0]             state;
  logic [CW-1:0]          last_chn;
  logic [CW-1:0]          arb_chn;
  logic [CW-1:0]          idx;
  logic                   arb_hit;
  logic [11:0]            word_cnt;
  logic [11:0]            cnt_next;
  logic [CNT_CHANNLS-1:0] elig;
  logic                   chn_nempt;
  logic                   busy_done;

  assign elig = mltcn ? ch_nempt : {{(CNT_CHANNLS-1){1'b0}}, ch_nempt[0]};

  // Search upward from last_chn+1; offset CNT_CHANNLS wraps back onto last_chn itself.
  always_comb begin
    arb_chn = '0;
    arb_hit = 1'b0;
    idx     = '0;
    for (int i = 1; i <= CNT_CHANNLS; i++) begin
      idx = last_chn + CW'(i);
      if (!arb_hit && elig[idx]) begin
        arb_chn = idx;
        arb_hit = 1'b1;
      end
    end
  end

  assign chn_nempt = ch_nempt[grt_chn];
  assign cnt_next  = (word_stb && word_cnt != BMAX) ? word_cnt + 12'd1 : word_cnt;
  assign busy_done = (cnt_next == BMAX) || !chn_nempt || txe_n;

  assign grt_vld   = (state == GRANT) || (state == BUSY);
  assign grt_oh    = grt_vld ? (CNT_CHANNLS'(1) << grt_chn) : '0;
  assign burst_end = (state == BUSY) && busy_done;
  assign burst_len = burst_end ? cnt_next : 12'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grt_chn  <= '0;
      last_chn <= CW'(CNT_CHANNLS - 1);
      word_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          word_cnt <= '0;
          if (sched_req && !txe_n && (|elig)) state <= ARB;
        end
        ARB: begin
          if (arb_hit) begin
            grt_chn <= arb_chn;
            state   <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          word_cnt <= '0;
          if (!chn_nempt)   state <= IDLE;
          else if (grt_ack) state <= BUSY;
        end
        BUSY: begin
          if (busy_done) begin
            last_chn <= grt_chn;
            word_cnt <= '0;
            state    <= IDLE;
          end else begin
            word_cnt <= cnt_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MST_SCHED_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grt_cnt <= '0;
    end else if (burst_end) begin
      for (int c = 0; c < CNT_CHANNLS; c++) begin
        if (grt_chn == CW'(c) && grt_cnt[c*16 +: 16] != 16'hFFFF)
          grt_cnt[c*16 +: 16] <= grt_cnt[c*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule
